alu_result_stage: RTL
=====================

Name: alu_result_stage

Overview:
Registered output stage directly downstream of the 4-bit arithmetic/logic extender. It captures each ALU result (Output, Cout) together with the 3-bit Control code that produced it. It derives status flags and buffers results in a small FIFO behind a valid/ready handshake. It also keeps a saturating count of accepted operations for the DSP sequencer.

Parameters:
DATA_W, 4, result width; must match ALU Output width
DEPTH, 2, FIFO entries; power of two, minimum 2
CNT_W, 8, width of accepted-operation counter

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  ALU result presented this cycle
in_ready  output  1  stage can accept a result this cycle
in_result  input  DATA_W  ALU Output
in_cout  input  1  ALU Cout
in_ctrl  input  3  ALU Control code that produced in_result
out_valid  output  1  head entry valid
out_ready  input  1  consumer accepts head entry
out_result  output  DATA_W  head result
out_flags  output  4  head flags {N,Z,C,L}
out_ctrl  output  3  head Control code
clr  input  1  synchronous clear of op_count and sticky_c (FIFO unaffected)
op_count  output  CNT_W  accepted pushes, saturating
sticky_c  output  1  sticky carry (see Optional Feature)

Behaviour:
- Push when in_valid && in_ready; pop when out_valid && out_ready.
- in_ready = (count < DEPTH). It is registered state only, with no combinational path from out_ready. When the FIFO is full, in_ready is low even if a pop occurs that cycle.
- out_valid = (count != 0). out_result, out_flags and out_ctrl come from the head entry and are held stable while out_valid && !out_ready.
- Latency: a push into an empty FIFO gives out_valid=1 on the next rising edge. No same-cycle bypass.
- Flags are computed at push time and stored with the entry:
  - N = in_result[DATA_W-1]
  - Z = (in_result == 0)
  - C = in_cout when in_ctrl[2]==0 (arithmetic codes 000-011), else 0
  - L = in_ctrl[2] (logic-class operation)
- Simultaneous push and pop with 0 < count < DEPTH: count unchanged, entry written at the tail, head advances.
- Read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits.
- in_valid while full: no write, no count change, op_count unchanged. Upstream must hold its data.
- out_ready while empty: no effect. Pointers unchanged.
- Entry storage is not reset. Only pointers, count and counters are reset.
- op_count increments by 1 per push and saturates at 2^CNT_W-1 (no wrap).
- clr takes priority over a same-cycle increment: op_count becomes 0 and the push is still accepted into the FIFO.
- Reset (asynchronous, any time including mid-transfer) drives:
  - pointers = 0, count = 0, out_valid = 0, in_ready = 1
  - op_count = 0, sticky_c = 0
  - out_result, out_flags and out_ctrl read as 0 while empty
  - any in-flight entries are discarded
- After rst_n deasserts, the first push is accepted on the first rising edge.

Optional Feature:
Macro ALU_STICKY_CARRY_EN.
- Defined: sticky_c is set on any push whose C flag = 1. It stays set until clr or reset. If clr and a carry-setting push occur in the same cycle, clr wins and sticky_c = 0.
- Not defined: sticky_c is tied to 0 and no register is inferred.

Test Plan:
- Reset then single push: in_result=4'b0000, in_cout=1, in_ctrl=000 -> next cycle out_valid=1, out_flags=4'b0110, op_count=1.
- Logic op flag masking: in_result=4'b1010, in_cout=1, in_ctrl=110 -> out_flags=4'b1001 (C suppressed, L set).
- Fill with out_ready=0: push 3 back-to-back with DEPTH=2 -> in_ready=0 after 2nd accept, 3rd not accepted, op_count=2. Then out_ready=1 -> entries pop in order; in_ready returns to 1 the cycle after the first pop.
- Steady stream: in_valid=1 and out_ready=1 every cycle for 10 results 0..9 -> outputs 0..9 in order, count stays 1, pointers wrap cleanly.
- Counter saturation with CNT_W=2: 5 pushes -> op_count sticks at 3. clr with a simultaneous push -> op_count=0, entry still buffered.
- Reset mid-operation with 2 entries buffered -> out_valid=0 and in_ready=1 immediately (async). With ALU_STICKY_CARRY_EN, carry push then clr -> sticky_c 1 then 0.

Source files
------------

// File: rtl/alu_result_stage.sv
// alu_result_stage: registered output stage behind the 4-bit ALU extender.
// Each accepted ALU result is stored with its Control code and derived flags
// {N,Z,C,L} in a small FIFO with a valid/ready handshake on both sides. A
// saturating counter tracks accepted pushes.
//
// Optional feature: define ALU_STICKY_CARRY_EN to build the sticky-carry
// register. Without it, sticky_c is tied to 0.
module alu_result_stage #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic              in_cout,
    input  logic [2:0]        in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [3:0]        out_flags,
    output logic [2:0]        out_ctrl,
    input  logic              clr,
    output logic [CNT_W-1:0]  op_count,
    output logic              sticky_c
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned FILL_W = PTR_W + 1;
    localparam logic [FILL_W-1:0] FULL_COUNT = FILL_W'(DEPTH);
    localparam logic [CNT_W-1:0]  OP_MAX     = '1;

    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [FILL_W-1:0] count_q;
    logic [CNT_W-1:0]  op_count_q;

    // Entry storage carries no reset; valid entries are tracked by count_q.
    logic [DATA_W-1:0] mem_result [DEPTH];
    logic [3:0]        mem_flags  [DEPTH];
    logic [2:0]        mem_ctrl   [DEPTH];

    logic       push;
    logic       pop;
    logic [3:0] in_flags;

    // in_ready depends only on registered occupancy, never on out_ready.
    assign in_ready  = (count_q < FULL_COUNT);
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Flags {N,Z,C,L}; carry is only meaningful for arithmetic codes (ctrl[2]==0).
    always_comb begin
        in_flags = {in_result[DATA_W-1],
                    (in_result == '0),
                    (~in_ctrl[2]) & in_cout,
                    in_ctrl[2]};
    end

    // Write the tail entry on every accepted push.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_result[wr_ptr_q] <= in_result;
            mem_flags[wr_ptr_q]  <= in_flags;
            mem_ctrl[wr_ptr_q]   <= in_ctrl;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + FILL_W'(1);
            end else if (!push && pop) begin
                count_q <= count_q - FILL_W'(1);
            end
        end
    end

    // Saturating count of accepted pushes; clr overrides a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count_q <= '0;
        end else if (clr) begin
            op_count_q <= '0;
        end else if (push && (op_count_q != OP_MAX)) begin
            op_count_q <= op_count_q + CNT_W'(1);
        end
    end

    assign op_count = op_count_q;

    // Head entry is presented only while valid so an empty stage reads as zero.
    always_comb begin
        out_result = '0;
        out_flags  = '0;
        out_ctrl   = '0;
        if (out_valid) begin
            out_result = mem_result[rd_ptr_q];
            out_flags  = mem_flags[rd_ptr_q];
            out_ctrl   = mem_ctrl[rd_ptr_q];
        end
    end

`ifdef ALU_STICKY_CARRY_EN
    logic sticky_q;

    // Sticky carry: set by any pushed entry whose C flag is 1, cleared by clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= 1'b0;
        end else if (clr) begin
            sticky_q <= 1'b0;
        end else if (push && in_flags[1]) begin
            sticky_q <= 1'b1;
        end
    end

    assign sticky_c = sticky_q;
`else
    assign sticky_c = 1'b0;
`endif

endmodule
